vga_num_regs: RTL and testbench

Memory-mapped register bank holding the sixteen 16-bit values shown on the VGA number grid. Sits between the CPU data bus (MEM-stage peripheral port) and `vga_control`, driving its `number0`…`number15` inputs. CPU reads and writes go through a four-phase request/ready handshake. Display updates are optionally double-buffered so a frame never shows a half-updated grid.

---
 rtl/vga_num_regs_if.sv | 13 +
 rtl/vga_num_regs.sv | 137 +++++++++++++
 tb/tb_vga_num_regs.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_num_regs_if.sv
// CPU-side request/ready bus for the VGA number register bank.
// Four-phase handshake: the master holds ce_in high until it sees ready_out, then drops it.
interface vga_num_regs_if;
   logic        ce_in;
   logic        we_in;
   logic [15:0] addr_in;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        ready_out;

   modport master (output ce_in, we_in, addr_in, data_in, input data_out, ready_out);
   modport slave  (input ce_in, we_in, addr_in, data_in, output data_out, ready_out);
endinterface

// File: rtl/vga_num_regs.sv
// Sixteen 16-bit display registers behind a four-phase CPU handshake; ready two edges after the request is sampled.
// Define VGA_NUM_DBUF_EN to double-buffer display updates and commit them on frame_sync_in rising edges.
module vga_num_regs #(
   parameter logic [15:0] BASE_ADDR = 16'hBF10
) (
   input  logic        clk,
   input  logic        rst,
   vga_num_regs_if.slave bus,
   input  logic        frame_sync_in,
   output logic [15:0] number0,
   output logic [15:0] number1,
   output logic [15:0] number2,
   output logic [15:0] number3,
   output logic [15:0] number4,
   output logic [15:0] number5,
   output logic [15:0] number6,
   output logic [15:0] number7,
   output logic [15:0] number8,
   output logic [15:0] number9,
   output logic [15:0] number10,
   output logic [15:0] number11,
   output logic [15:0] number12,
   output logic [15:0] number13,
   output logic [15:0] number14,
   output logic [15:0] number15
);

   typedef enum logic [1:0] {
      INIT  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      HOLD  = 2'b11
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] shadow [16];
   logic [15:0] view   [16];
   logic        we_q, hit_q;
   logic [3:0]  idx_q;
   logic [15:0] data_q;
   logic [15:0] rd_data;
   logic        hit;
   logic        wr_hit;

   assign hit           = (bus.addr_in[15:4] == BASE_ADDR[15:4]);
   assign wr_hit        = (state == WRITE) && we_q && hit_q;
   assign bus.ready_out = (state == HOLD);
   assign bus.data_out  = rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:        if (bus.ce_in) state_nxt = bus.we_in ? WRITE : READ;
         READ, WRITE: state_nxt = HOLD;
         HOLD:        if (!bus.ce_in) state_nxt = INIT;
         default:     state_nxt = INIT;
      endcase
   end

   // Request fields are captured once so the master may change them after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q   <= 1'b0;
         hit_q  <= 1'b0;
         idx_q  <= 4'd0;
         data_q <= 16'h0000;
      end else if (state == INIT && bus.ce_in) begin
         we_q   <= bus.we_in;
         hit_q  <= hit;
         idx_q  <= bus.addr_in[3:0];
         data_q <= bus.data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) shadow[i] <= 16'h0000;
         rd_data <= 16'h0000;
      end else begin
         if (state == READ) rd_data <= hit_q ? shadow[idx_q] : 16'h0000;
         if (wr_hit)        shadow[idx_q] <= data_q;
      end
   end

`ifdef VGA_NUM_DBUF_EN
   logic [15:0] disp [16];
   logic        dirty, sync_d;
   logic        commit;

   assign commit = frame_sync_in && !sync_d && dirty;

   // A write landing on the commit edge re-arms dirty so its value shows next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) disp[i] <= 16'h0000;
         dirty  <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         sync_d <= frame_sync_in;
         if (commit) begin
            for (int i = 0; i < 16; i++) disp[i] <= shadow[i];
            dirty <= 1'b0;
         end
         if (wr_hit) dirty <= 1'b1;
      end
   end

   assign view = disp;
`else
   logic unused_frame_sync;
   assign unused_frame_sync = frame_sync_in;
   assign view = shadow;
`endif

   assign number0  = view[0];
   assign number1  = view[1];
   assign number2  = view[2];
   assign number3  = view[3];
   assign number4  = view[4];
   assign number5  = view[5];
   assign number6  = view[6];
   assign number7  = view[7];
   assign number8  = view[8];
   assign number9  = view[9];
   assign number10 = view[10];
   assign number11 = view[11];
   assign number12 = view[12];
   assign number13 = view[13];
   assign number14 = view[14];
   assign number15 = view[15];

endmodule

// File: tb/tb_vga_num_regs.sv
// Bench for vga_num_regs: transaction-level register model checked every cycle, directed cases plus random traffic.
module tb_vga_num_regs;
   localparam logic [15:0] BASE = 16'hBF10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fs  = 1'b0;
   logic [15:0] nums [16];

   vga_num_regs_if bus ();

   vga_num_regs #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .bus(bus), .frame_sync_in(fs),
      .number0(nums[0]),   .number1(nums[1]),   .number2(nums[2]),   .number3(nums[3]),
      .number4(nums[4]),   .number5(nums[5]),   .number6(nums[6]),   .number7(nums[7]),
      .number8(nums[8]),   .number9(nums[9]),   .number10(nums[10]), .number11(nums[11]),
      .number12(nums[12]), .number13(nums[13]), .number14(nums[14]), .number15(nums[15])
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;
   bit rand_fs = 1'b0;

   logic [15:0] shadow_m [16];
   logic [15:0] disp_m   [16];
   bit          dirty_m, sync_m, exp_ready;
   logic [15:0] exp_dout;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] shown(input int i);
`ifdef VGA_NUM_DBUF_EN
      return disp_m[i];
`else
      return shadow_m[i];
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         shadow_m[i] = 16'h0000;
         disp_m[i]   = 16'h0000;
      end
      dirty_m = 0; sync_m = 0; exp_ready = 0; exp_dout = 16'h0000;
   endfunction

   // One clock edge: frame commit sees the pre-write register contents, then any write lands.
   task automatic tick(input bit do_wr, input int idx, input logic [15:0] val);
      @(posedge clk); #1;
      if (fs && !sync_m && dirty_m) begin
         disp_m  = shadow_m;
         dirty_m = 0;
      end
      sync_m = fs;
      if (do_wr) begin
         shadow_m[idx] = val;
         dirty_m = 1;
      end
      if (rand_fs) fs = ($urandom_range(0, 2) == 0);
   endtask

   task automatic xact(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int hold, input bit fs_exec);
      bit hit;
      hit = (a[15:4] == BASE[15:4]);
      bus.ce_in = 1'b1; bus.we_in = w; bus.addr_in = a; bus.data_in = d;
      tick(0, 0, 16'h0);
      chk("ready_after_accept", 16'(bus.ready_out), 16'h0);
      bus.we_in   = 1'($urandom);
      bus.addr_in = 16'($urandom);
      bus.data_in = 16'($urandom);
      if (fs_exec) fs = 1'b1;
      tick(w && hit, int'(a[3:0]), d);
      if (!w) exp_dout = hit ? shadow_m[a[3:0]] : 16'h0000;
      exp_ready = 1;
      chk("ready_two_edges", 16'(bus.ready_out), 16'h1);
      if (!w) chk("read_data", bus.data_out, exp_dout);
      repeat (hold) tick(0, 0, 16'h0);
      bus.ce_in = 1'b0;
      tick(0, 0, 16'h0);
      exp_ready = 0;
      chk("ready_released", 16'(bus.ready_out), 16'h0);
   endtask

   task automatic frame_pulse();
      fs = 1'b0; tick(0, 0, 16'h0);
      fs = 1'b1; tick(0, 0, 16'h0);
      fs = 1'b0; tick(0, 0, 16'h0);
   endtask

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            for (int i = 0; i < 16; i++)
               chk($sformatf("number%0d", i), nums[i], shown(i));
            chk("ready_out", 16'(bus.ready_out), 16'(exp_ready));
            chk("data_out", bus.data_out, exp_dout);
         end
      end
   end

   initial begin
      bus.ce_in = 1'b0; bus.we_in = 1'b0; bus.addr_in = 16'h0; bus.data_in = 16'h0;
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;

      chk("reset_ready", 16'(bus.ready_out), 16'h0);
      chk("reset_dout", bus.data_out, 16'h0000);
      for (int i = 0; i < 16; i++) chk("reset_number", nums[i], 16'h0000);

      // Write then read back one entry.
      xact(1, 16'hBF13, 16'h1234, 1, 0);
`ifdef VGA_NUM_DBUF_EN
      chk("number3_before_frame", nums[3], 16'h0000);
      frame_pulse();
`endif
      chk("number3_shown", nums[3], 16'h1234);
      xact(0, 16'hBF13, 16'h0000, 2, 0);
      chk("readback_bf13", bus.data_out, 16'h1234);

      // Misses complete without side effects.
      xact(1, 16'hBF20, 16'hFFFF, 0, 0);
      xact(0, 16'hBF20, 16'h0000, 0, 0);
      chk("miss_read", bus.data_out, 16'h0000);
`ifdef VGA_NUM_DBUF_EN
      frame_pulse();
`endif
      chk("miss_number3", nums[3], 16'h1234);
      chk("miss_number0", nums[0], 16'h0000);

      // Asynchronous reset mid-cycle.
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_ready", 16'(bus.ready_out), 16'h0);
      chk("async_rst_dout", bus.data_out, 16'h0000);
      chk("async_rst_number3", nums[3], 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      xact(0, 16'hBF13, 16'h0000, 0, 0);
      chk("post_rst_read", bus.data_out, 16'h0000);

      // Write landing on the frame commit edge.
      xact(1, 16'hBF10, 16'h0055, 0, 0);
      xact(1, 16'hBF10, 16'h00AA, 0, 1);
`ifdef VGA_NUM_DBUF_EN
      chk("simul_number0_old", nums[0], 16'h0055);
      frame_pulse();
`endif
      chk("simul_number0_new", nums[0], 16'h00AA);

      // Back-to-back sweep of every entry, one commit.
      for (int n = 0; n < 16; n++) xact(1, BASE + 16'(n), 16'(n) * 16'h0101, 0, 0);
`ifdef VGA_NUM_DBUF_EN
      frame_pulse();
`endif
      for (int n = 0; n < 16; n++) chk("sweep_number", nums[n], 16'(n) * 16'h0101);
      for (int n = 0; n < 16; n++) begin
         xact(0, BASE + 16'(n), 16'h0000, 0, 0);
         chk("sweep_read", bus.data_out, 16'(n) * 16'h0101);
      end

      // Reset after a write is accepted but before it executes.
      bus.ce_in = 1'b1; bus.we_in = 1'b1; bus.addr_in = 16'hBF15; bus.data_in = 16'hBEEF;
      tick(0, 0, 16'h0);
      #2 rst = 1'b1;
      model_reset();
      bus.ce_in = 1'b0;
      #1 chk("rst_write_ready", 16'(bus.ready_out), 16'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      xact(0, 16'hBF15, 16'h0000, 0, 0);
      chk("rst_write_lost", bus.data_out, 16'h0000);

      // Random traffic with random frame strobes.
      rand_fs = 1'b1;
      for (int k = 0; k < 250; k++) begin
         logic [15:0] a;
         if ($urandom_range(0, 7) == 0) a = 16'($urandom);
         else a = {BASE[15:4], 4'($urandom)};
         xact(1'($urandom), a, 16'($urandom), $urandom_range(0, 2), 0);
         if ($urandom_range(0, 3) == 0) tick(0, 0, 16'h0);
      end
      rand_fs = 1'b0;
      fs = 1'b0;
      repeat (3) tick(0, 0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
